// File: rtl/if_id_stage.sv
// if_id_stage
//   Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
//   It owns the PC and addresses the asynchronous-read instruction ROM.
//   It latches the fetched word into ID.
//   It stalls on a load-use dependency, flushes on an EX-stage redirect,
//   and freezes permanently (until reset) on a syscall halt.
//   It also keeps the cycle, stall and flush counters shown on the board display.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   dependency          load-use hazard from the hazard detector (current cycle)
//   redirect            taken branch/jump resolved in EX
//   redirect_pc         redirect target; bits [1:0] are ignored
//   halt                syscall halt decoded in EX
//   imem_data           instruction word read at imem_addr
//   pc, imem_addr       current fetch PC and its word address
//   id_ir, id_pc4       instruction in ID and its PC+4
//   id_valid            ID holds a real instruction (0 = bubble)
//   idex_bubble         ID/EX must load a NOP this cycle
//   halted              front end frozen
//   cycle_cnt, stall_cnt, flush_cnt   performance counters (wrapping)
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dependency,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        id_ir,
  output logic [31:0]        id_pc4,
  output logic               id_valid,
  output logic               idex_bubble,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic [31:0]        pc_plus4;

  // Redirect targets are word aligned; the low two bits carry no information.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cycle_d = cycle_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q == S_RUN) begin
      cycle_d = cycle_q + CNT_W'(1);
      if (halt) begin
        state_d = S_HALTED;
      end else if (redirect) begin
        // Squash the wrong-path instruction in ID; a coincident load-use
        // stall is moot because that instruction is discarded anyway.
        pc_d    = {redirect_pc[31:2], 2'b00};
        ir_d    = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        flush_d = flush_q + CNT_W'(1);
      end else if (dependency) begin
        stall_d = stall_q + CNT_W'(1);
      end else begin
        pc_d    = pc_plus4;
        ir_d    = imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halted      = (state_q == S_HALTED);
  // Downstream is draining once halted, so no bubble is requested then.
  assign idex_bubble = !halted && (dependency || redirect);
  assign pc          = pc_q;
  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign id_ir       = ir_q;
  assign id_pc4      = pc4_q;
  assign id_valid    = valid_q;
  assign cycle_cnt   = cycle_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule
